tms_sdm_delay_scan: RTL and testbench

Sequencer that sweeps the input IDELAY tap of each selected SDM data lane over all 32 taps. At each tap it counts bit transitions of the sampled lane over a programmable window and streams the per-tap counts into a result buffer for software eye finding. It sits between the control register file and the SDM receiver: it drives the receiver's delay-programming inputs (channel, value, update pulse) and observes the receiver's CLK-domain data output.

---
 rtl/tms_pkg.sv | 17 +
 rtl/tms_sdm_edge_counter.sv | 40 ++++
 rtl/tms_sdm_delay_scan.sv | 174 +++++++++++++++++
 tb/tb_tms_sdm_delay_scan.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tms_pkg.sv
// Shared types and sizes for the SDM delay-scan sequencer and its edge counter.
package tms_pkg;
  localparam int NTAP           = 32;
  localparam int TAP_WIDTH      = 5;
  localparam int CHAN_WIDTH     = 8;
  localparam int RES_ADDR_WIDTH = CHAN_WIDTH + TAP_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_STORE   = 3'd4,
    ST_APPLY   = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;
endpackage

// File: rtl/tms_sdm_edge_counter.sv
// Selects one receiver lane and counts its bit transitions, saturating at all-ones.
module tms_sdm_edge_counter
  import tms_pkg::*;
#(
  parameter int NLANE     = 38,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_cap,
  input  logic                  i_en,
  input  logic [CHAN_WIDTH-1:0] i_lane,
  input  logic [NLANE-1:0]      i_din,
  output logic [CNT_WIDTH-1:0]  o_count
);
  logic [255:0]         w_pad;
  logic                 w_bit;
  logic                 r_prev;
  logic [CNT_WIDTH-1:0] r_count;

  // Zero-padded so any 8-bit lane index is in range.
  assign w_pad   = 256'(i_din);
  assign w_bit   = w_pad[i_lane];
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_clr)
        r_count <= '0;
      else if (i_en && (w_bit != r_prev) && (r_count != {CNT_WIDTH{1'b1}}))
        r_count <= r_count + 1'b1;
      if (i_cap || i_en)
        r_prev <= w_bit;
    end
  end
endmodule

// File: rtl/tms_sdm_delay_scan.sv
// Sweeps the IDELAY tap of each selected SDM lane and logs per-tap transition counts.
// TMS_SDM_SCAN_AUTOSET_EN adds an APPLY step that programs each lane's lowest-count tap.
module tms_sdm_delay_scan
  import tms_pkg::*;
#(
  parameter int NCH          = 19,
  parameter int CNT_WIDTH    = 16,
  parameter int SETTLE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic [CHAN_WIDTH-1:0]     CHAN_FIRST,
  input  logic [CHAN_WIDTH-1:0]     CHAN_LAST,
  input  logic [SETTLE_WIDTH-1:0]   SETTLE_CYCLES,
  input  logic [3:0]                WINDOW_LOG2,
  input  logic [NCH*2-1:0]          DIN,
  output logic [CHAN_WIDTH-1:0]     DELAY_CHANNEL,
  output logic [TAP_WIDTH-1:0]      DELAY_VALUE,
  output logic                      DELAY_UPDATE,
  output logic                      RES_WE,
  output logic [RES_ADDR_WIDTH-1:0] RES_ADDR,
  output logic [CNT_WIDTH-1:0]      RES_DATA,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR
);
  localparam logic [CHAN_WIDTH:0] NLANE = (CHAN_WIDTH+1)'(2*NCH);

  state_t                  r_state;
  logic [CHAN_WIDTH-1:0]   r_lane, r_last, r_dly_chan;
  logic [TAP_WIDTH-1:0]    r_tap, r_dly_val;
  logic [SETTLE_WIDTH-1:0] r_settle_cfg, r_settle_cnt;
  logic [3:0]              r_wlog2;
  logic [15:0]             r_win_cnt;
  logic                    r_err;
  logic [CNT_WIDTH-1:0]    w_count;
  logic                    w_range_ok, w_settle_last, w_win_last, w_lane_last;
  logic [15:0]             w_win_max;

  assign w_range_ok    = (CHAN_FIRST <= CHAN_LAST) && ({1'b0, CHAN_LAST} < NLANE);
  assign w_settle_last = (r_settle_cnt == r_settle_cfg);
  assign w_win_max     = (16'd1 << r_wlog2) - 16'd1;
  assign w_win_last    = (r_win_cnt == w_win_max);
  assign w_lane_last   = (r_lane == r_last);

`ifdef TMS_SDM_SCAN_AUTOSET_EN
  logic [TAP_WIDTH-1:0] r_best_tap, w_best_tap;
  logic [CNT_WIDTH-1:0] r_best_cnt;
  logic                 w_take;
  // Strict less-than keeps the lowest tap on ties.
  assign w_take     = (r_tap == '0) || (w_count < r_best_cnt);
  assign w_best_tap = w_take ? r_tap : r_best_tap;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_last       <= '0;
      r_tap        <= '0;
      r_dly_chan   <= '0;
      r_dly_val    <= '0;
      r_settle_cfg <= '0;
      r_settle_cnt <= '0;
      r_wlog2      <= '0;
      r_win_cnt    <= '0;
      r_err        <= 1'b0;
`ifdef TMS_SDM_SCAN_AUTOSET_EN
      r_best_tap   <= '0;
      r_best_cnt   <= '0;
`endif
    end else if (ABORT) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (START) begin
          if (w_range_ok) begin
            r_lane       <= CHAN_FIRST;
            r_last       <= CHAN_LAST;
            r_settle_cfg <= SETTLE_CYCLES;
            r_wlog2      <= WINDOW_LOG2;
            r_tap        <= '0;
            r_dly_chan   <= CHAN_FIRST;
            r_dly_val    <= '0;
            r_err        <= 1'b0;
            r_state      <= ST_LOAD;
          end else begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_LOAD: begin
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          r_win_cnt    <= '0;
          if (w_settle_last) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          r_win_cnt <= r_win_cnt + 16'd1;
          if (w_win_last) r_state <= ST_STORE;
        end
        ST_STORE: begin
`ifdef TMS_SDM_SCAN_AUTOSET_EN
          r_best_tap <= w_best_tap;
          if (w_take) r_best_cnt <= w_count;
`endif
          if (r_tap != 5'd31) begin
            r_tap     <= r_tap + 1'b1;
            r_dly_val <= r_tap + 1'b1;
            r_state   <= ST_LOAD;
          end else begin
`ifdef TMS_SDM_SCAN_AUTOSET_EN
            r_dly_val <= w_best_tap;
            r_state   <= ST_APPLY;
`else
            if (!w_lane_last) begin
              r_lane     <= r_lane + 1'b1;
              r_dly_chan <= r_lane + 1'b1;
              r_tap      <= '0;
              r_dly_val  <= '0;
              r_state    <= ST_LOAD;
            end else begin
              r_state <= ST_FINISH;
            end
`endif
          end
        end
`ifdef TMS_SDM_SCAN_AUTOSET_EN
        ST_APPLY: begin
          if (!w_lane_last) begin
            r_lane     <= r_lane + 1'b1;
            r_dly_chan <= r_lane + 1'b1;
            r_tap      <= '0;
            r_dly_val  <= '0;
            r_state    <= ST_LOAD;
          end else begin
            r_state <= ST_FINISH;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tms_sdm_edge_counter #(
    .NLANE     (NCH*2),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_edge (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clr   (r_state == ST_LOAD),
    .i_cap   ((r_state == ST_SETTLE) && w_settle_last),
    .i_en    (r_state == ST_MEASURE),
    .i_lane  (r_lane),
    .i_din   (DIN),
    .o_count (w_count)
  );

  assign DELAY_CHANNEL = r_dly_chan;
  assign DELAY_VALUE   = r_dly_val;
  assign DELAY_UPDATE  = (r_state == ST_LOAD) || (r_state == ST_APPLY);
  assign RES_WE        = (r_state == ST_STORE);
  assign RES_ADDR      = {r_lane, r_tap};
  assign RES_DATA      = w_count;
  assign BUSY          = (r_state != ST_IDLE);
  assign DONE          = (r_state == ST_FINISH);
  assign ERR           = r_err;
endmodule

// File: tb/tb_tms_sdm_delay_scan.sv
// Directed bench for tms_sdm_delay_scan; build with TMS_SDM_SCAN_AUTOSET_EN to cover APPLY.
module tb_tms_sdm_delay_scan;
  localparam int NCH = 19;
`ifdef TMS_SDM_SCAN_AUTOSET_EN
  localparam int APPLY_X = 1;
`else
  localparam int APPLY_X = 0;
`endif

  logic             clk = 1'b0, rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, sat_start = 1'b0, sat_abort = 1'b0;
  logic [7:0]       chan_first = '0, chan_last = '0, settle = '0;
  logic [3:0]       wlog2 = '0;
  logic [NCH*2-1:0] din = '0;
  int               din_mode = 0;

  logic [7:0]  dly_chan;
  logic [4:0]  dly_val;
  logic        dly_upd, res_we, busy, done, err;
  logic [12:0] res_addr;
  logic [15:0] res_data;

  logic [7:0]  s_chan;
  logic [4:0]  s_val;
  logic        s_upd, s_we, s_busy, s_done, s_err;
  logic [12:0] s_addr;
  logic [3:0]  s_data;

  always #5 clk = ~clk;

  tms_sdm_delay_scan #(.NCH(NCH), .CNT_WIDTH(16), .SETTLE_WIDTH(8)) u_dut (
    .CLK(clk), .RESET(rst), .START(start), .ABORT(abort),
    .CHAN_FIRST(chan_first), .CHAN_LAST(chan_last), .SETTLE_CYCLES(settle),
    .WINDOW_LOG2(wlog2), .DIN(din),
    .DELAY_CHANNEL(dly_chan), .DELAY_VALUE(dly_val), .DELAY_UPDATE(dly_upd),
    .RES_WE(res_we), .RES_ADDR(res_addr), .RES_DATA(res_data),
    .BUSY(busy), .DONE(done), .ERR(err));

  // Narrow-counter instance so saturation is reachable within one window.
  tms_sdm_delay_scan #(.NCH(NCH), .CNT_WIDTH(4), .SETTLE_WIDTH(8)) u_sat (
    .CLK(clk), .RESET(rst), .START(sat_start), .ABORT(sat_abort),
    .CHAN_FIRST(chan_first), .CHAN_LAST(chan_last), .SETTLE_CYCLES(settle),
    .WINDOW_LOG2(wlog2), .DIN(din),
    .DELAY_CHANNEL(s_chan), .DELAY_VALUE(s_val), .DELAY_UPDATE(s_upd),
    .RES_WE(s_we), .RES_ADDR(s_addr), .RES_DATA(s_data),
    .BUSY(s_busy), .DONE(s_done), .ERR(s_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane data: 0 constant, 1 toggle every cycle, 2 toggle except while taps 12..20 are applied.
  always @(posedge clk) begin
    #1;
    case (din_mode)
      0:       din = '0;
      1:       din = ~din;
      default: din = (dly_val >= 5'd12 && dly_val <= 5'd20) ? '0 : ~din;
    endcase
  end

  int we_cyc[$], we_addr[$], we_data[$], upd_cyc[$], upd_chan[$], upd_val[$];
  int done_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (res_we) begin
      we_cyc.push_back(cyc); we_addr.push_back(int'(res_addr)); we_data.push_back(int'(res_data));
    end
    if (dly_upd) begin
      upd_cyc.push_back(cyc); upd_chan.push_back(int'(dly_chan)); upd_val.push_back(int'(dly_val));
    end
    if (done) begin
      done_cnt++; done_cyc = cyc;
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic clear_logs();
    we_cyc.delete(); we_addr.delete(); we_data.delete();
    upd_cyc.delete(); upd_chan.delete(); upd_val.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int first, last, settle, wlog2, mode;
    int exp_err, exp_nwe, exp_addr, exp_data, exp_period;
  } vec_t;
  vec_t vec[5];

  initial begin
    int  sc, bad_addr, bad_data, bad_per, nl, n;
    bit  ok;

    vec[0] = '{3, 3, 2, 4, 1, 0, 32, 'h060, 16, 21};
    vec[1] = '{5, 6, 0, 2, 0, 0, 64, 'h0A0, 0, 7};
    vec[2] = '{10, 9, 0, 0, 0, 1, 0, 0, 0, 0};
    vec[3] = '{0, 38, 0, 0, 0, 1, 0, 0, 0, 0};
    vec[4] = '{37, 37, 0, 0, 1, 0, 32, 'h4A0, 1, 4};

    repeat (3) @(negedge clk);
    check("rst_busy_async", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_upd", dly_upd, 0);
    check("rst_we", res_we, 0);
    check("rst_chan", dly_chan, 0);
    check("rst_val", dly_val, 0);
    check("rst_addr", res_addr, 0);
    check("rst_data", res_data, 0);

    for (int i = 0; i < 5; i++) begin
      clear_logs();
      chan_first = 8'(vec[i].first); chan_last = 8'(vec[i].last);
      settle = 8'(vec[i].settle); wlog2 = 4'(vec[i].wlog2); din_mode = vec[i].mode;
      @(negedge clk);
      pulse_start(sc);
      wait_done(5000, ok);
      check($sformatf("v%0d_done_seen", i), ok, 1);
      @(negedge clk);
      nl = vec[i].exp_nwe / 32;
      check($sformatf("v%0d_err", i), err, vec[i].exp_err);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_we_cnt", i), we_cyc.size(), vec[i].exp_nwe);
      check($sformatf("v%0d_upd_cnt", i), upd_cyc.size(), vec[i].exp_nwe + APPLY_X * nl);
      if (vec[i].exp_err != 0) begin
        // DONE is high in the cycle after the START edge, i.e. the second cycle counting START.
        check($sformatf("v%0d_done_lat", i), done_cyc - sc, 0);
      end else if (upd_cyc.size() > 0 && we_cyc.size() > 0) begin
        check($sformatf("v%0d_upd_lat", i), upd_cyc[0] - sc, 0);
        check($sformatf("v%0d_chan_first", i), upd_chan[0], vec[i].first);
        check($sformatf("v%0d_chan_last", i), upd_chan[upd_chan.size()-1], vec[i].last);
        check($sformatf("v%0d_chan_hold", i), dly_chan, vec[i].last);
        bad_addr = 0; bad_data = 0; bad_per = 0;
        for (int k = 0; k < we_cyc.size(); k++) begin
          if (we_addr[k] != vec[i].exp_addr + k) bad_addr++;
          if (we_data[k] != vec[i].exp_data) bad_data++;
          if (k > 0 && (we_cyc[k] - we_cyc[k-1]) !=
              vec[i].exp_period + ((k % 32 == 0) ? APPLY_X : 0)) bad_per++;
        end
        check($sformatf("v%0d_addr_seq", i), bad_addr, 0);
        check($sformatf("v%0d_data", i), bad_data, 0);
        check($sformatf("v%0d_tap_period", i), bad_per, 0);
      end
      $display("vec %0d: lanes %0d..%0d writes=%0d updates=%0d err=%0d", i,
               vec[i].first, vec[i].last, we_cyc.size(), upd_cyc.size(), err);
    end

    // START coinciding with DONE must be ignored.
    clear_logs();
    chan_first = 8'd37; chan_last = 8'd37; settle = 8'd0; wlog2 = 4'd0; din_mode = 1;
    pulse_start(sc);
    wait_done(5000, ok);
    check("sd_done_seen", ok, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sd_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("sd_upd_cnt", upd_cyc.size(), 32 + APPLY_X);
    $display("start-at-done: busy=%0d updates=%0d", busy, upd_cyc.size());

    // ABORT wins over START in IDLE.
    clear_logs();
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("as_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("as_upd_cnt", upd_cyc.size(), 0);
    $display("abort+start idle: busy=%0d", busy);

    // ABORT during MEASURE of tap 7.
    clear_logs();
    chan_first = 8'd1; chan_last = 8'd1; settle = 8'd1; wlog2 = 4'd3; din_mode = 1;
    pulse_start(sc);
    n = 0;
    for (int k = 0; k < 2000 && n < 7; k++) begin
      if (res_we) n++;
      if (n < 7) @(negedge clk);
    end
    check("ab_reach_tap6", n, 7);
    repeat (4) @(negedge clk);
    check("ab_tap", dly_val, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 0);
    repeat (60) @(negedge clk);
    check("ab_we_cnt", we_cyc.size(), 7);
    check("ab_upd_cnt", upd_cyc.size(), 8);
    check("ab_done_cnt", done_cnt, 0);
    pulse_start(sc);
    check("ab_restart_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_restart_abort", busy, 0);
    $display("abort tap7: writes=%0d updates=%0d done=%0d", we_cyc.size(), upd_cyc.size(), done_cnt);

    // Asynchronous reset mid-scan.
    chan_first = 8'd3; chan_last = 8'd3; settle = 8'd2; wlog2 = 4'd4;
    pulse_start(sc);
    repeat (30) @(negedge clk);
    check("ar_pre_chan", dly_chan, 3);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_chan", dly_chan, 0);
    check("ar_val", dly_val, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("async reset: busy=%0d chan=%0d", busy, dly_chan);

    // Saturation on the 4-bit instance: 16 transitions clamp at 15.
    chan_first = 8'd0; chan_last = 8'd0; settle = 8'd0; wlog2 = 4'd4; din_mode = 1;
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (s_we) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("sat_we_seen", ok, 1);
    check("sat_data", s_data, 15);
    sat_abort = 1'b1;
    @(negedge clk);
    sat_abort = 1'b0;
    check("sat_abort_busy", s_busy, 0);
    $display("saturation: data=%0d", s_data);

`ifdef TMS_SDM_SCAN_AUTOSET_EN
    clear_logs();
    chan_first = 8'd2; chan_last = 8'd2; settle = 8'd0; wlog2 = 4'd2; din_mode = 2;
    pulse_start(sc);
    wait_done(5000, ok);
    check("au_done_seen", ok, 1);
    @(negedge clk);
    check("au_we_cnt", we_cyc.size(), 32);
    check("au_upd_cnt", upd_cyc.size(), 33);
    if (upd_val.size() == 33 && we_data.size() == 32) begin
      check("au_best", upd_val[32], 12);
      check("au_tap11", we_data[11], 4);
      check("au_tap12", we_data[12], 0);
    end
    check("au_hold", dly_val, 12);
    $display("autoset: applied tap=%0d", dly_val);
`endif

    din_mode = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
